// File: rtl/emu_ckpt_ctrl.sv
// Checkpoint sequencer: pauses the target, streams the FF chain then the RAM chain
// over 64-bit valid/ready ports (dump or load), then resumes. Option: EMU_CKPT_ABORT_EN.
module emu_ckpt_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int FF_WORDS   = 4,
  parameter int MEM_WORDS  = 16,
  parameter int RAM_PRIME  = 2,
  parameter int RAM_FLUSH  = 1
) (
  input  logic                  host_clk,
  input  logic                  host_rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  output logic                  done,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  run_mode,
  output logic                  scan_mode,
  output logic                  ff_se,
  output logic                  ff_dir,
  output logic [DATA_WIDTH-1:0] ff_di,
  input  logic [DATA_WIDTH-1:0] ff_do,
  output logic                  ram_sr,
  output logic                  ram_se,
  output logic                  ram_sd,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
`ifdef EMU_CKPT_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam int MAXW = (FF_WORDS > MEM_WORDS) ? FF_WORDS : MEM_WORDS;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam int PMAX = (RAM_PRIME > RAM_FLUSH) ? RAM_PRIME : RAM_FLUSH;
  localparam int PW   = $clog2(PMAX + 1) + 1;

  localparam logic [CW-1:0] FF_LAST    = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] MEM_LAST   = CW'(MEM_WORDS - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'((RAM_PRIME > 0) ? RAM_PRIME - 1 : 0);
  localparam logic [PW-1:0] FLUSH_LAST = PW'((RAM_FLUSH > 0) ? RAM_FLUSH - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_PAUSE, S_SCAN_ON, S_RAM_RST, S_FF_XFER,
    S_RAM_PRIME, S_RAM_XFER, S_RAM_FLUSH, S_SCAN_OFF, S_RESUME
  } state_t;

  state_t                  state, nxt;
  logic                    dir;
  logic [CW-1:0]           cnt;
  logic [PW-1:0]           pcnt;
  logic [DATA_WIDTH-1:0]   last_word;
  logic                    xfer;
  logic                    abort_hit;

`ifdef EMU_CKPT_ABORT_EN
  assign abort_hit = abort && (state inside {S_PAUSE, S_SCAN_ON, S_RAM_RST, S_FF_XFER,
                                             S_RAM_PRIME, S_RAM_XFER, S_RAM_FLUSH});
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    nxt       = state;
    cmd_ready = 1'b0;
    busy      = (state != S_IDLE);
    run_mode  = 1'b0;
    scan_mode = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    in_ready  = 1'b0;
    ff_se     = 1'b0;
    ff_dir    = 1'b0;
    ff_di     = '0;
    ram_sr    = 1'b0;
    ram_se    = 1'b0;
    ram_sd    = 1'b0;
    ram_di    = '0;
    xfer      = 1'b0;
    case (state)
      S_IDLE: begin
        run_mode  = 1'b1;
        cmd_ready = host_rstn;
        if (cmd_valid) nxt = S_PAUSE;
      end
      S_PAUSE:   nxt = S_SCAN_ON;
      S_SCAN_ON: begin
        scan_mode = 1'b1;
        nxt       = S_RAM_RST;
      end
      S_RAM_RST: begin
        scan_mode = 1'b1;
        ram_sr    = 1'b1;
        nxt       = S_FF_XFER;
      end
      S_FF_XFER: begin
        scan_mode = 1'b1;
        ff_dir    = dir;
        if (!dir) begin
          out_valid = 1'b1;
          out_data  = ff_do;
          xfer      = out_ready;
        end else begin
          in_ready = 1'b1;
          ff_di    = in_data;
          xfer     = in_valid;
        end
        ff_se = xfer;
        if (xfer && cnt == FF_LAST)
          nxt = (!dir && RAM_PRIME > 0) ? S_RAM_PRIME : S_RAM_XFER;
      end
      S_RAM_PRIME: begin
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        if (pcnt == PRIME_LAST) nxt = S_RAM_XFER;
      end
      S_RAM_XFER: begin
        scan_mode = 1'b1;
        ram_sd    = dir;
        if (!dir) begin
          out_valid = 1'b1;
          out_data  = ram_do;
          xfer      = out_ready;
        end else begin
          in_ready = 1'b1;
          ram_di   = in_data;
          xfer     = in_valid;
        end
        ram_se = xfer;
        if (xfer && cnt == MEM_LAST)
          nxt = (dir && RAM_FLUSH > 0) ? S_RAM_FLUSH : S_SCAN_OFF;
      end
      S_RAM_FLUSH: begin
        scan_mode = 1'b1;
        ram_se    = 1'b1;
        ram_sd    = 1'b1;
        ram_di    = last_word;
        if (pcnt == FLUSH_LAST) nxt = S_SCAN_OFF;
      end
      S_SCAN_OFF: nxt = S_RESUME;
      S_RESUME: begin
        run_mode = 1'b1;
        nxt      = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // An abort silences every chain strobe and stream handshake in the cycle it is seen.
    if (abort_hit) begin
      nxt       = S_SCAN_OFF;
      xfer      = 1'b0;
      ff_se     = 1'b0;
      ram_se    = 1'b0;
      ram_sr    = 1'b0;
      out_valid = 1'b0;
      in_ready  = 1'b0;
    end
  end

  always_ff @(posedge host_clk) begin
    if (!host_rstn) begin
      state     <= S_IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      pcnt      <= '0;
      last_word <= '0;
      done      <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (state == S_RESUME);
      if (state == S_IDLE && cmd_valid) dir <= cmd_dir;
      if (nxt != state)  cnt <= '0;
      else if (xfer)     cnt <= cnt + CW'(1);
      if (nxt != state)  pcnt <= '0;
      else if (state == S_RAM_PRIME || state == S_RAM_FLUSH) pcnt <= pcnt + PW'(1);
      // Flush cycles keep presenting the final load word to the RAM chain.
      if (state == S_RAM_XFER && dir && xfer) last_word <= in_data;
    end
  end

`ifdef EMU_CKPT_ABORT_EN
  always_ff @(posedge host_clk) begin
    if (!host_rstn)                        aborted <= 1'b0;
    else if (state == S_IDLE && cmd_valid) aborted <= 1'b0;
    else if (abort_hit)                    aborted <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_emu_ckpt_ctrl.sv
// Bench for emu_ckpt_ctrl: chain model (rotating FF chain, RAM with read/write latency),
// random backpressure, scoreboard of stream words against the model contents.
module tb_emu_ckpt_ctrl;
  localparam int DW = 64, FFW = 3, MW = 5, PR = 2, FL = 1;
  localparam int NW = FFW + MW;

  logic host_clk = 1'b0, host_rstn;
  logic cmd_valid, cmd_ready, cmd_dir, done, busy;
  logic out_valid, out_ready, in_valid, in_ready;
  logic [DW-1:0] out_data, in_data, ff_di, ff_do, ram_di, ram_do;
  logic run_mode, scan_mode, ff_se, ff_dir, ram_sr, ram_se, ram_sd;
`ifdef EMU_CKPT_ABORT_EN
  logic abort, aborted, s_aborted;
`endif

  always #5 host_clk = ~host_clk;

  emu_ckpt_ctrl #(.DATA_WIDTH(DW), .FF_WORDS(FFW), .MEM_WORDS(MW),
                  .RAM_PRIME(PR), .RAM_FLUSH(FL)) dut (
    .host_clk(host_clk), .host_rstn(host_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .done(done), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .run_mode(run_mode), .scan_mode(scan_mode),
    .ff_se(ff_se), .ff_dir(ff_dir), .ff_di(ff_di), .ff_do(ff_do),
    .ram_sr(ram_sr), .ram_se(ram_se), .ram_sd(ram_sd), .ram_di(ram_di), .ram_do(ram_do)
`ifdef EMU_CKPT_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  // Snapshots of the previous cycle, taken at the falling edge.
  logic s_rst, s_run, s_scan, s_busy, s_done, s_cmd_ready, s_out_valid, s_in_ready;
  logic s_ff_se, s_ff_dir, s_ram_sr, s_ram_se, s_ram_sd, s_in_hs;
  logic [DW-1:0] s_ff_di, s_ram_di;
  int cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0, sr_cnt = 0, hs_bad = 0;
  logic [DW-1:0] oq[$], ffq[$], rq[$];

  // Chain model
  logic [DW-1:0] ff_q[FFW], mem[MW], rpipe[PR], wbuf;
  int rd_ptr, wr_ptr;
  logic wvld;
  logic [31:0] seed;
  logic scramble;
  assign ff_do  = ff_q[0];
  assign ram_do = rpipe[PR-1];

  always @(posedge host_clk) cyc <= cyc + 1;

  always @(posedge host_clk) begin
    if (s_rst) begin
      for (int i = 0; i < FFW; i++) ff_q[i] <= {seed + 32'(i), 32'hF000_0000 | 32'(i)};
      for (int i = 0; i < MW; i++)  mem[i]  <= {~seed + 32'(i * 7), 32'h0000_0010 + 32'(i)};
      rd_ptr <= 0; wr_ptr <= 0; wvld <= 1'b0;
    end else if (scramble) begin
      for (int i = 0; i < FFW; i++) ff_q[i] <= ~ff_q[i];
      for (int i = 0; i < MW; i++)  mem[i]  <= mem[i] ^ 64'h5555_AAAA_5555_AAAA;
    end else begin
      if (s_ff_se) begin
        for (int i = 0; i < FFW - 1; i++) ff_q[i] <= ff_q[i+1];
        ff_q[FFW-1] <= s_ff_dir ? s_ff_di : ff_q[0];
      end
      if (s_ram_sr) begin
        rd_ptr <= 0; wr_ptr <= 0; wvld <= 1'b0;
      end else if (s_ram_se && !s_ram_sd) begin
        rpipe[0] <= mem[rd_ptr % MW];
        for (int i = 1; i < PR; i++) rpipe[i] <= rpipe[i-1];
        rd_ptr <= rd_ptr + 1;
      end else if (s_ram_se && s_ram_sd) begin
        wbuf <= s_ram_di;
        wvld <= 1'b1;
        if (wvld && wr_ptr < MW) begin
          mem[wr_ptr] <= wbuf;
          wr_ptr <= wr_ptr + 1;
        end
      end
    end
  end

  always @(negedge host_clk) begin
    s_rst <= !host_rstn; s_run <= run_mode; s_scan <= scan_mode; s_busy <= busy;
    s_done <= done; s_cmd_ready <= cmd_ready; s_out_valid <= out_valid; s_in_ready <= in_ready;
    s_ff_se <= ff_se; s_ff_dir <= ff_dir; s_ff_di <= ff_di;
    s_ram_sr <= ram_sr; s_ram_se <= ram_se; s_ram_sd <= ram_sd; s_ram_di <= ram_di;
    s_in_hs <= in_valid && in_ready;
`ifdef EMU_CKPT_ABORT_EN
    s_aborted <= aborted;
`endif
    if (out_valid && out_ready) oq.push_back(out_data);
    if (ff_se && ff_dir)        ffq.push_back(ff_di);
    if (ram_se && ram_sd)       rq.push_back(ram_di);
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (ram_sr) sr_cnt <= sr_cnt + 1;
    // Chain strobes must track the stream handshake exactly while a stream port is open.
    if ((out_valid && ((ff_se | ram_se) != out_ready)) ||
        (in_ready && ((ff_se | ram_se) != in_valid)) ||
        (ff_se && !ff_dir && !(out_valid && out_ready)))
      hs_bad <= hs_bad + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [DW-1:0] ld_words[NW], exp_w[NW], got_w[NW];
  int ld_idx;
  bit rnd_in, rnd_out;

  task automatic tick();
    @(posedge host_clk); #1;
    if (s_in_hs && ld_idx < NW) ld_idx++;
    in_data   = ld_words[(ld_idx < NW) ? ld_idx : NW - 1];
    in_valid  = rnd_in  ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 600 && done_cnt == base; i++) tick();
    chk("done_seen", 64'(done_cnt != base), 64'd1);
  endtask

  task automatic run_op(input logic d, output int lat);
    int base;
    base = done_cnt;
    cmd_dir = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_done(base);
    lat = done_cyc - acc_cyc;
  endtask

  task automatic snap_exp();
    for (int i = 0; i < FFW; i++) exp_w[i] = ff_q[i];
    for (int i = 0; i < MW; i++)  exp_w[FFW+i] = mem[i];
  endtask

  task automatic chk_dump(input string tag, input int base);
    chk({tag, "_count"}, 64'(oq.size() - base), 64'(NW));
    for (int i = 0; i < NW; i++)
      if (base + i < oq.size()) chk(tag, oq[base+i], exp_w[i]);
  endtask

  initial begin
    int lat, ob, fb, rb, hb, sb, base;
    seed = $urandom; scramble = 1'b0;
    host_rstn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0;
    out_ready = 1'b1; in_valid = 1'b0; in_data = '0;
    rnd_in = 0; rnd_out = 0; ld_idx = 0;
    for (int i = 0; i < NW; i++) ld_words[i] = '0;
`ifdef EMU_CKPT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_run_mode", 64'(s_run), 64'd1);
    chk("rst_scan_mode", 64'(s_scan), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_strobes", 64'({s_out_valid, s_in_ready, s_ff_se, s_ram_se, s_ram_sr}), 64'd0);
`ifdef EMU_CKPT_ABORT_EN
    chk("rst_aborted", 64'(s_aborted), 64'd0);
`endif
    host_rstn = 1'b1;
    tick();

    // Dump, no backpressure
    snap_exp(); ob = oq.size(); sb = sr_cnt; hb = hs_bad;
    run_op(1'b0, lat);
    chk("dump_latency", 64'(lat), 64'd16);
    chk_dump("dump_word", ob);
    chk("ram_sr_cycles", 64'(sr_cnt - sb), 64'd1);
    chk("idle_run_mode", 64'(s_run), 64'd1);

    // Dump, random out_ready
    rnd_out = 1; snap_exp(); ob = oq.size();
    run_op(1'b0, lat);
    rnd_out = 0;
    chk_dump("bp_dump_word", ob);
    chk("dump_se_handshake", 64'(hs_bad - hb), 64'd0);

    // Load 1..8, random in_valid
    for (int i = 0; i < NW; i++) ld_words[i] = 64'(i + 1);
    ld_idx = 0; rnd_in = 1; fb = ffq.size(); rb = rq.size(); hb = hs_bad;
    run_op(1'b1, lat);
    rnd_in = 0;
    chk("ld_ff_count", 64'(ffq.size() - fb), 64'(FFW));
    for (int i = 0; i < FFW; i++) if (fb + i < ffq.size()) chk("ld_ff_di", ffq[fb+i], 64'(i + 1));
    chk("ld_ram_count", 64'(rq.size() - rb), 64'(MW + FL));
    for (int i = 0; i < MW; i++) if (rb + i < rq.size()) chk("ld_ram_di", rq[rb+i], 64'(FFW + i + 1));
    if (rb + MW < rq.size()) chk("ld_flush_word", rq[rb+MW], 64'(NW));
    chk("load_se_handshake", 64'(hs_bad - hb), 64'd0);
    for (int i = 0; i < FFW; i++) chk("ld_ff_model", ff_q[i], 64'(i + 1));
    for (int i = 0; i < MW; i++)  chk("ld_mem_model", mem[i], 64'(FFW + i + 1));

    // Round trip: dump, corrupt, load back
    snap_exp(); ob = oq.size();
    run_op(1'b0, lat);
    for (int i = 0; i < NW; i++) got_w[i] = (ob + i < oq.size()) ? oq[ob+i] : '0;
    scramble = 1'b1; tick(); scramble = 1'b0;
    for (int i = 0; i < NW; i++) ld_words[i] = got_w[i];
    ld_idx = 0;
    run_op(1'b1, lat);
    chk("load_latency", 64'(lat), 64'd15);
    for (int i = 0; i < FFW; i++) chk("rt_ff", ff_q[i], exp_w[i]);
    for (int i = 0; i < MW; i++)  chk("rt_mem", mem[i], exp_w[FFW+i]);
    chk("rt_run_mode", 64'(s_run), 64'd1);

    // Reset in the middle of RAM_XFER, then immediate new command
    base = done_cnt; cmd_dir = 1'b0; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    repeat (9) tick();
    chk("mid_in_ram_xfer", 64'({s_scan, s_out_valid}), 64'b11);
    host_rstn = 1'b0; tick();
    host_rstn = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b0;
    tick(); cmd_valid = 1'b0;
    chk("mr_run_mode", 64'(s_run), 64'd1);
    chk("mr_scan_mode", 64'(s_scan), 64'd0);
    chk("mr_busy", 64'(s_busy), 64'd0);
    chk("mr_cmd_ready", 64'(s_cmd_ready), 64'd1);
    chk("mr_no_done", 64'(done_cnt - base), 64'd0);
    snap_exp(); ob = oq.size();
    wait_done(base);
    chk("mr_latency", 64'(done_cyc - acc_cyc), 64'd16);
    chk_dump("mr_dump_word", ob);

`ifdef EMU_CKPT_ABORT_EN
    cmd_dir = 1'b0; cmd_valid = 1'b1;
    tick(); cmd_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1; tick();
    abort = 1'b0; tick();
    chk("ab_scan_mode", 64'(s_scan), 64'd0);
    chk("ab_ff_se", 64'(s_ff_se), 64'd0);
    tick();
    chk("ab_run_mode", 64'(s_run), 64'd1);
    tick();
    chk("ab_done", 64'(s_done), 64'd1);
    chk("ab_aborted", 64'(s_aborted), 64'd1);
    snap_exp(); ob = oq.size();
    run_op(1'b0, lat);
    chk("ab_clear", 64'(s_aborted), 64'd0);
    chk_dump("ab_next_dump", ob);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
